alu: RTL and testbench

//   8-bit registered arithmetic/compare unit for the datapath.

---
 rtl/alu.sv | 29 ++
 tb/tb_alu.sv | 118 +++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: registered add/sub/mul-low/equal/greater-than unit with hold-on-disable.
module alu #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  enable_in,
    input  logic [2:0]            opcode_in,
    input  logic [DATA_WIDTH-1:0] alu_input1,
    input  logic [DATA_WIDTH-1:0] alu_input2,
    output logic [DATA_WIDTH-1:0] alu_output
);
    logic [DATA_WIDTH-1:0] result_q, result_d, op_res, mul_lo, eq_res, gt_res;
    assign mul_lo = alu_input1 * alu_input2;
    assign eq_res = {{(DATA_WIDTH-1){1'b0}}, alu_input1 == alu_input2};
    assign gt_res = {{(DATA_WIDTH-1){1'b0}}, alu_input1 > alu_input2};
    always_comb begin
        op_res   = opcode_in == 3'b000 ? alu_input1 + alu_input2 :
                   opcode_in == 3'b001 ? alu_input1 - alu_input2 :
                   opcode_in == 3'b010 ? mul_lo :
                   opcode_in == 3'b011 ? eq_res :
                   opcode_in == 3'b100 ? gt_res : '0;
        result_d = enable_in ? op_res : result_q;
    end
    always_ff @(posedge clock_in or negedge reset_in)
        if (!reset_in) result_q <= '0;
        else           result_q <= result_d;
    assign alu_output = result_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu; expected results queued at drive time, popped at output.
module tb_alu;
    logic       clock_in = 1'b0;
    logic       reset_in, enable_in;
    logic [2:0] opcode_in;
    logic [7:0] alu_input1, alu_input2, alu_output;
    logic [7:0] exp_q[$];
    logic [7:0] held;
    int         n_cmp = 0, n_err = 0;
    alu dut (
        .clock_in(clock_in), .reset_in(reset_in), .enable_in(enable_in),
        .opcode_in(opcode_in), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_output(alu_output)
    );
    always #5 clock_in = ~clock_in;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            3'd0:    return 8'((9'(a) + 9'(b)) % 256);
            3'd1:    return 8'((9'(a) + 9'd256 - 9'(b)) % 256);
            3'd2:    return p[7:0];
            3'd3:    return (a == b) ? 8'h01 : 8'h00;
            3'd4:    return (a > b) ? 8'h01 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction
    // Called at a falling edge: drive, let one rising edge capture, compare at next falling edge.
    task automatic step(input string tag, input logic en, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b);
        enable_in = en; opcode_in = op; alu_input1 = a; alu_input2 = b;
        if (en) held = model(op, a, b);
        exp_q.push_back(held);
        @(posedge clock_in);
        @(negedge clock_in);
        if (exp_q.size() == 0) check({tag, "_empty"}, alu_output, 8'hxx);
        else check(tag, alu_output, exp_q.pop_front());
    endtask
    task automatic known(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] lit);
        step(tag, 1'b1, op, a, b);
        check({tag, "_lit"}, held, lit);
    endtask
    initial begin
        logic [7:0] bvals[6];
        reset_in = 1'b0; enable_in = 1'b1; opcode_in = 3'b000;
        alu_input1 = 8'h12; alu_input2 = 8'h34; held = 8'h00;
        #1 check("rst_async", alu_output, 8'h00);
        repeat (3) begin
            @(negedge clock_in);
            check("rst_hold", alu_output, 8'h00);
        end
        reset_in = 1'b1;
        #1 check("rst_release", alu_output, 8'h00);
        @(negedge clock_in);
        check("rst_first", alu_output, 8'h12 + 8'h34);
        known("add_200_100", 3'b000, 8'd200, 8'd100, 8'h2C);
        known("add_255_1",   3'b000, 8'd255, 8'd1,   8'h00);
        known("sub_5_10",    3'b001, 8'd5,   8'd10,  8'hFB);
        known("sub_0_1",     3'b001, 8'd0,   8'd1,   8'hFF);
        known("sub_0_255",   3'b001, 8'd0,   8'd255, 8'h01);
        known("mul_0f_11",   3'b010, 8'h0F,  8'h11,  8'hFF);
        known("mul_255_255", 3'b010, 8'd255, 8'd255, 8'h01);
        known("mul_16_16",   3'b010, 8'd16,  8'd16,  8'h00);
        known("eq_7_7",      3'b011, 8'd7,   8'd7,   8'h01);
        known("eq_7_8",      3'b011, 8'd7,   8'd8,   8'h00);
        known("eq_0_0",      3'b011, 8'd0,   8'd0,   8'h01);
        known("gt_200_100",  3'b100, 8'd200, 8'd100, 8'h01);
        known("gt_100_200",  3'b100, 8'd100, 8'd200, 8'h00);
        known("gt_50_50",    3'b100, 8'd50,  8'd50,  8'h00);
        known("gt_0_0",      3'b100, 8'd0,   8'd0,   8'h00);
        known("en_load",     3'b000, 8'd3,   8'd4,   8'h07);
        step("en_hold1", 1'b0, 3'b010, 8'd9, 8'd9);
        step("en_hold2", 1'b0, 3'b001, 8'd1, 8'd200);
        check("en_hold_val", alu_output, 8'h07);
        known("rsv_101", 3'b101, 8'd9, 8'd9, 8'h00);
        known("add_nz",  3'b000, 8'd1, 8'd1, 8'h02);
        known("rsv_110", 3'b110, 8'd9, 8'd9, 8'h00);
        known("add_nz2", 3'b000, 8'd1, 8'd2, 8'h03);
        known("rsv_111", 3'b111, 8'd9, 8'd9, 8'h00);
        for (int a = 0; a < 256; a++) begin
            bvals = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd255, 8'($urandom_range(0, 255))};
            for (int k = 0; k < 6; k++)
                for (int op = 0; op < 5; op++)
                    step("sweep", 1'b1, 3'(op), 8'(a), bvals[k]);
        end
        for (int i = 0; i < 3000; i++)
            step("stream", $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        known("pre_rst", 3'b000, 8'd10, 8'd20, 8'd30);
        enable_in = 1'b1; opcode_in = 3'b000; alu_input1 = 8'd50; alu_input2 = 8'd60;
        @(posedge clock_in);
        #2 reset_in = 1'b0;
        #1 check("mid_rst_async", alu_output, 8'h00);
        @(negedge clock_in);
        check("mid_rst_hold", alu_output, 8'h00);
        @(posedge clock_in);
        @(negedge clock_in);
        check("mid_rst_edge", alu_output, 8'h00);
        reset_in = 1'b1;
        #1 check("mid_rst_release", alu_output, 8'h00);
        exp_q.delete();
        held = 8'h00;
        step("post_rst_idle", 1'b0, 3'b000, 8'd1, 8'd1);
        for (int i = 0; i < 200; i++)
            step("post_rst", $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
